// File: rtl/spi_slave_pkg.sv
// Shared sizing for the SPI mode-0 slave: default word width and the derived bit-counter width.
// No timing or flow control lives here.
package spi_slave_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    // A counter for a 1-bit word still needs one bit of storage.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEF_CNT_WIDTH = cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/spi_slave_shift.sv
// Receive half of the SPI slave: MOSI shift register, bit counter and word-complete strobe.
// Word lands on the DATA_WIDTH-th SCLK rise; SS high clears the frame asynchronously, no backpressure.
module spi_slave_shift
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
    input  logic                  SCLK,
    input  logic                  RESET,
    input  logic                  SS,
    input  logic                  MOSI,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic [DATA_WIDTH-1:0] rx_word,
    output logic                  word_last,
    output logic                  data_valid
);

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    // The oldest bit never needs storing: it leaves the register on the same edge the word completes.
    logic [DATA_WIDTH-2:0] rx_shift;

    assign rx_word   = {rx_shift, MOSI};
    assign word_last = (bit_cnt == LAST_BIT);

    always_ff @(posedge SCLK or posedge RESET or posedge SS) begin
        if (RESET) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            data_valid <= 1'b0;
        end else if (SS) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            data_valid <= 1'b0;
        end else begin
            rx_shift   <= rx_word[DATA_WIDTH-2:0];
            data_valid <= word_last;
            bit_cnt    <= word_last ? '0 : bit_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first: deserialises MOSI into received_data and serialises data_to_send onto MISO.
// received_data/data_valid update on the DATA_WIDTH-th SCLK rise; the master paces everything, no backpressure.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  SCLK,
    input  logic                  RESET,
    input  logic                  MOSI,
    input  logic                  SS,
    input  logic [DATA_WIDTH-1:0] data_to_send,
    output logic                  MISO,
    output logic [DATA_WIDTH-1:0] received_data,
    output logic                  data_valid
);

    localparam int CNT_WIDTH = cnt_width(DATA_WIDTH);

    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  word_last;
    logic [DATA_WIDTH-1:0] tx_hold;
    logic [DATA_WIDTH-1:0] tx_aligned;

    spi_slave_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_shift (
        .SCLK       (SCLK),
        .RESET      (RESET),
        .SS         (SS),
        .MOSI       (MOSI),
        .bit_cnt    (bit_cnt),
        .rx_word    (rx_word),
        .word_last  (word_last),
        .data_valid (data_valid)
    );

    // received_data survives deselect, so only RESET clears it.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            tx_hold       <= '0;
            received_data <= '0;
        end else if (!SS) begin
            if (bit_cnt == '0) begin
                tx_hold <= data_to_send;
            end
            if (word_last) begin
                received_data <= rx_word;
            end
        end
    end

    assign tx_aligned = tx_hold << bit_cnt;

    // Bit 0 comes straight from data_to_send so the MSB is on the wire before the first rise.
    always_comb begin
        MISO = 1'b0;
        if (!SS) begin
            MISO = (bit_cnt == '0) ? data_to_send[DATA_WIDTH-1] : tx_aligned[DATA_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed scenarios plus random frames, checked against a bit-level master model.
module tb_spi_slave;

    localparam int W = 8;

    logic         SCLK;
    logic         RESET;
    logic         MOSI;
    logic         SS;
    logic [W-1:0] data_to_send;
    logic         MISO;
    logic [W-1:0] received_data;
    logic         data_valid;

    spi_slave #(.DATA_WIDTH(W)) dut (
        .SCLK          (SCLK),
        .RESET         (RESET),
        .MOSI          (MOSI),
        .SS            (SS),
        .data_to_send  (data_to_send),
        .MISO          (MISO),
        .received_data (received_data),
        .data_valid    (data_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: position within the word, received value so far, word being transmitted.
    int           n_bits = 0;
    int           acc    = 0;
    logic [W-1:0] cap    = '0;
    logic [W-1:0] exp_rd = '0;
    logic         exp_dv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One 10 ns SCLK period: MISO checked where the master samples it, outputs checked after the rise.
    task automatic clock_bit(input logic b);
        logic exp_miso;
        MOSI = b;
        #4;
        if (n_bits == 0) exp_miso = data_to_send[W-1];
        else             exp_miso = 1'((cap >> (W - 1 - n_bits)) & 1);
        chk("miso", {31'd0, MISO}, {31'd0, exp_miso});
        if (n_bits == 0) cap = data_to_send;
        #1 SCLK = 1'b1;
        acc    = acc * 2 + int'(b);
        n_bits = n_bits + 1;
        exp_dv = 1'b0;
        if (n_bits == W) begin
            exp_rd = W'(acc);
            exp_dv = 1'b1;
            n_bits = 0;
            acc    = 0;
        end
        #2;
        chk("data_valid", {31'd0, data_valid}, {31'd0, exp_dv});
        chk("received_data", {24'd0, received_data}, {24'd0, exp_rd});
        #3 SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] v, input int nb);
        for (int i = 0; i < nb; i++) clock_bit(v[W-1-i]);
    endtask

    task automatic frame_start();
        SS = 1'b0;
        #2;
        chk("miso_first", {31'd0, MISO}, {31'd0, data_to_send[W-1]});
        #3;
    endtask

    task automatic frame_end();
        SS = 1'b1;
        #2;
        n_bits = 0;
        acc    = 0;
        exp_dv = 1'b0;
        chk("dv_idle", {31'd0, data_valid}, {31'd0, exp_dv});
        chk("rd_idle", {24'd0, received_data}, {24'd0, exp_rd});
        chk("miso_idle", {31'd0, MISO}, 32'd0);
        #3;
    endtask

    initial begin
        SCLK = 1'b0;
        RESET = 1'b1;
        SS = 1'b1;
        MOSI = 1'b0;
        data_to_send = '0;
        #20;
        chk("rst_rd", {24'd0, received_data}, 32'd0);
        chk("rst_dv", {31'd0, data_valid}, 32'd0);
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        RESET = 1'b0;
        #5;

        // Single byte followed by two continuous all-ones words.
        data_to_send = 8'hC1;
        frame_start();
        send_bits(8'hC1, W);
        chk("byte_c1", {24'd0, received_data}, 32'hC1);
        send_bits(8'hFF, W);
        send_bits(8'hFF, W);
        frame_end();

        // Aborted partial word, then a clean frame from a restarted counter.
        data_to_send = 8'h00;
        frame_start();
        send_bits(8'hA5, 5);
        frame_end();
        chk("abort_keep", {24'd0, received_data}, 32'hFF);
        frame_start();
        send_bits(8'h3C, W);
        frame_end();

        // Asynchronous reset in the middle of a word, no SCLK involved.
        data_to_send = 8'h96;
        frame_start();
        send_bits(8'h5A, 3);
        RESET = 1'b1;
        #2;
        n_bits = 0;
        acc    = 0;
        exp_rd = '0;
        exp_dv = 1'b0;
        chk("midrst_rd", {24'd0, received_data}, 32'd0);
        chk("midrst_dv", {31'd0, data_valid}, 32'd0);
        chk("midrst_miso", {31'd0, MISO}, {31'd0, data_to_send[W-1]});
        #3 RESET = 1'b0;
        frame_end();
        frame_start();
        send_bits(8'h5A, W);
        chk("after_rst", {24'd0, received_data}, 32'h5A);
        frame_end();

        // data_to_send changes after bit 2; the word in flight must not notice.
        data_to_send = 8'h81;
        frame_start();
        send_bits(8'h00, 3);
        data_to_send = 8'h7E;
        send_bits(8'h00, 5);
        send_bits(8'h00, W);
        frame_end();

        // Random frames with random lengths, data and mid-word data_to_send churn.
        for (int f = 0; f < 25; f++) begin
            data_to_send = W'($urandom);
            frame_start();
            for (int i = 0, nb = $urandom_range(1, 24); i < nb; i++) begin
                if (n_bits == 0 || $urandom_range(0, 3) == 0) data_to_send = W'($urandom);
                clock_bit(1'($urandom_range(0, 1)));
            end
            frame_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-0 slave (CPOL=0, CPHA=0), MSB first, single fixed-width word per transfer slot. It deserialises MOSI into a parallel word and pulses a valid flag per completed word. Simultaneously it serialises a parallel word onto MISO. It sits between an off-chip SPI master and on-chip logic, clocked entirely by the master's SCLK.

Parameters:
DATA_WIDTH, 8, bits per word (shift-register and counter width derive from it; counter width = clog2(DATA_WIDTH), minimum 1)

Ports:
SCLK  input  1  SPI serial clock from master; the block's only clock; all state changes on rising edge
RESET  input  1  asynchronous, active-high reset
MOSI  input  1  serial data from master, sampled on SCLK rising edge
SS  input  1  slave select, active low; high = idle/deselected
data_to_send  input  DATA_WIDTH  word to transmit; captured at the start of each word
MISO  output  1  serial data to master, MSB first
received_data  output  DATA_WIDTH  last completely received word
data_valid  output  1  one-SCLK-period pulse marking a new received_data

Behaviour:
- One clock domain (SCLK, rising edge); reset is asynchronous, active-high, on RESET.
- Reset values: bit_cnt=0, rx_shift=0, tx_hold=0, received_data=0, data_valid=0. MISO then reads 0 because SS is high or bit_cnt=0 selects data_to_send (see below).
- SS high acts as an asynchronous frame clear: bit_cnt=0, data_valid=0, rx_shift=0. received_data is retained. SCLK is held low by the master while deselected.
- Receive: on each rising edge with SS low, rx_shift <= {rx_shift[DATA_WIDTH-2:0], MOSI}, bit_cnt <= bit_cnt+1.
- Word complete on the rising edge where bit_cnt = DATA_WIDTH-1:
  - received_data <= {rx_shift[DATA_WIDTH-2:0], MOSI}
  - data_valid <= 1
  - bit_cnt wraps to 0
- Latency: received_data and data_valid update on the DATA_WIDTH-th rising edge after SS falls.
- data_valid is cleared on the next rising edge unless that edge also completes a word, which cannot happen for DATA_WIDTH>1.
- Back-to-back words: SS held low past DATA_WIDTH clocks starts the next word immediately, with no gap cycle.
- Transmit: MISO = 0 when SS high. Otherwise:
  - bit_cnt = 0: MISO = data_to_send[DATA_WIDTH-1], combinational, so the MSB is present before the first rising edge.
  - bit_cnt = k > 0: MISO = tx_hold[DATA_WIDTH-1-k].
  - tx_hold <= data_to_send on every rising edge where bit_cnt = 0.
  - MISO therefore changes just after rising edges; the master samples on the next rising edge.
  - data_to_send must be stable from SS fall (or word boundary) through the first rising edge of each word; later changes do not affect the word in flight.
- Partial word at SS rise: discarded, with no data_valid and received_data unchanged.
- RESET mid-word: the word is aborted, all state is cleared immediately, and received_data returns to 0.

Decomposition:
- Shared package: DATA_WIDTH default constant and derived CNT_WIDTH.
- No sub-module required; optionally split out a generic spi_shift_reg (rx shift + counter) used once.

Test Plan:
- Reset: RESET=1 for 20 ns with SS=1 -> received_data=0x00, data_valid=0, MISO=0.
- Single byte: SS low, MOSI=0xC1 MSB first, one bit per 10 ns SCLK period -> after 8th rising edge received_data=0xC1 and data_valid high for exactly one SCLK period. With data_to_send=0xC1, the MISO bits sampled on the 8 rising edges are 1,1,0,0,0,0,0,1.
- Continued clocking: SS held low 16 more clocks with MOSI=1 -> two further words, each received_data=0xFF with a one-cycle data_valid pulse; MISO repeats 0xC1 per word.
- Aborted frame: SS low, 5 bits of 0xA5 clocked, SS high -> no data_valid, received_data keeps its prior value. Next frame of 0x3C -> received_data=0x3C (counter restarted at 0).
- Reset mid-word: RESET asserted after 3 bits -> received_data=0, data_valid=0 immediately, asynchronously without SCLK. After release, a full 0x5A frame -> received_data=0x5A.
- data_to_send change mid-word: 0x81 captured, changed to 0x7E after bit 2 -> MISO still shifts 0x81. The next word transmits 0x7E.
